// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
// Round-robin arbiter that merges byte packets from four requesters into one
// byte stream for a serial transmitter. A packet owns the link from its first
// byte until the byte flagged with in_last. An optional header byte that
// identifies the source port is sent ahead of each packet.
//
// State table (state | meaning):
//   ST_IDLE    | no packet owns the link; pick the next requester round-robin
//   ST_HEADER  | packet granted; waiting to place the header byte
//   ST_PAYLOAD | forwarding bytes of the granted port until in_last
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   in_data    in   32  byte of port p on bits [8p+7:8p]
//   in_valid   in   4   per-port byte valid
//   in_last    in   4   per-port final-byte-of-packet flag
//   in_ready   out  4   per-port byte accepted
//   out_data   out  8   byte to the serial transmitter
//   out_valid  out  1   out_data holds a byte
//   out_ready  in   1   transmitter accepts the byte
//   grant      out  2   port currently owning the link
//   busy       out  1   high in ST_HEADER or ST_PAYLOAD
module rs232_tx_arbiter #(
    parameter bit          HEADER      = 1'b1,
    parameter logic [7:0]  HEADER_BASE = 8'hF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_valid,
    input  logic [3:0]  in_last,
    output logic [3:0]  in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] next_grant;
    logic       out_free;
    logic       pay_fire;
    logic [7:0] grant_byte;

    // The output register can take a new byte when it is empty or its
    // current byte is leaving on this edge.
    assign out_free   = !out_valid || out_ready;
    assign grant_byte = in_data[{grant, 3'b000} +: 8];
    assign pay_fire   = (state == ST_PAYLOAD) && out_free && in_valid[grant];
    assign busy       = (state != ST_IDLE);

    // Search upward from last_grant+1; the fourth candidate wraps back to
    // last_grant itself so a lone requester can be re-granted.
    always_comb begin
        logic found;
        logic [1:0] cand;
        found      = 1'b0;
        next_grant = last_grant;
        cand       = last_grant;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && in_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = 4'b0000;
        if (state == ST_PAYLOAD && out_free)
            in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            grant      <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            // A byte leaving with nothing loaded behind it empties the
            // register; out_data keeps its old value. Loads below override.
            if (out_ready)
                out_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|in_valid) begin
                        grant <= next_grant;
                        state <= HEADER ? ST_HEADER : ST_PAYLOAD;
                    end
                end
                ST_HEADER: begin
                    if (out_free) begin
                        out_data  <= {HEADER_BASE[7:2], grant};
                        out_valid <= 1'b1;
                        state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_fire) begin
                        out_data  <= grant_byte;
                        out_valid <= 1'b1;
                        if (in_last[grant]) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rs232_tx_arbiter.md
RS232_TX_ARBITER -- requirements
Module: rs232_tx_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- HEADER, 1: 1 = prepend one header byte per packet; 0 = payload only.
- HEADER_BASE, 8'hF0: header byte = HEADER_BASE with bits [1:0] replaced by the granted port number.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1: the single clock; all state on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- in_data, in, 32: byte of port p on bits [8p+7:8p], p = 0..3.
- in_valid, in, 4: per-port byte valid.
- in_last, in, 4: per-port flag marking the final byte of a packet.
- in_ready, out, 4: per-port byte accepted.
- out_data, out, 8: byte to the serial transmitter.
- out_valid, out, 1: out_data holds a byte.
- out_ready, in, 1: transmitter accepts the byte.
- grant, out, 2: port currently owning the link.
- busy, out, 1: high in HEADER or PAYLOAD.

Function
REQ-003 A transfer occurs on a port when in_valid[p] and in_ready[p] are both high on a rising clock edge; an output transfer occurs when out_valid and out_ready are both high.
REQ-004 The state machine has three states: IDLE, HEADER and PAYLOAD.
REQ-005 IDLE: if any in_valid bit is high, load grant with the first requesting port searching upward from last_grant+1 mod 4; next state is HEADER when HEADER=1, otherwise PAYLOAD; if no bit is high, stay in IDLE.
REQ-006 HEADER: when the output register is free (out_valid low or out_ready high), load out_data with the header byte, set out_valid and go to PAYLOAD.
REQ-007 PAYLOAD: in_ready[grant] = (out_valid low or out_ready high); all other in_ready bits are 0; in_ready is 0 in IDLE and HEADER.
REQ-008 On a payload transfer, load out_data with the granted port's byte and set out_valid in the same edge.
REQ-009 A payload transfer with in_last high sets last_grant to grant and returns to IDLE; arbitration for the next packet runs on the following cycle (one bubble minimum).
REQ-010 When the output register is free and no new byte is loaded, clear out_valid; out_data holds its value.
REQ-011 Hold out_data and out_valid unchanged while out_valid is high and out_ready is low.
REQ-012 grant changes only in IDLE; a requester that is not granted is never acknowledged, and its in_valid may stay high indefinitely.
REQ-013 Round-robin fairness: with all four ports requesting continuously, grants rotate 0,1,2,3,0,... one packet each.
REQ-014 A packet of N payload bytes produces exactly N+HEADER output transfers in order, with no byte dropped or duplicated under any out_ready pattern.
REQ-015 A single-byte packet (in_last on the first byte) is legal and follows REQ-009.
REQ-016 in_valid dropping mid-packet stalls the PAYLOAD state without releasing the grant.
REQ-017 busy = (state != IDLE); busy does not include a pending out_valid.

Reset
REQ-018 Reset is asynchronous and active-high; while it is high, state = IDLE, out_valid = 0, out_data = 0, grant = 0, last_grant = 3, in_ready = 0 and busy = 0.
REQ-019 Reset asserted mid-packet abandons that packet and discards any pending output byte; the first grant after reset goes to the lowest-numbered requesting port.

Verification
REQ-020 HEADER=1; port 2 sends 8'h41, 8'h42 (last); out_ready held high -> output sequence F2, 41, 42; grant=2 while busy; then IDLE.
REQ-021 All ports request a 1-byte packet each with data 10+p and out_ready held high -> output F0,10,F1,11,F2,12,F3,13, then port 0 is served next.
REQ-022 out_ready toggled randomly, 16-byte packet on port 1 -> all 17 bytes delivered in order; out_data stable whenever out_valid=1 and out_ready=0.
REQ-023 HEADER=0; port 3 sends 8'h55 (last) -> single output byte 55; in_ready[3] high for exactly one accepted transfer.
REQ-024 Reset pulsed after 3 bytes of a port-1 packet while port 0 requests -> out_valid=0 immediately; the next output is header F0.
REQ-025 Port 0 holds in_valid low for 5 cycles mid-packet while port 1 requests -> grant stays 0, no port-1 byte appears until port 0's last byte has been transferred.
